// File: rtl/scalar_wb_arbiter_pkg.sv
// rtl/scalar_wb_arbiter_pkg.sv - shared constants for the scalar register file write port
package scalar_wb_arbiter_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 8;
    localparam int NUM_REQ  = 3;

    localparam int REQ_ALU  = 0;
    localparam int REQ_LD   = 1;
    localparam int REQ_VMOV = 2;

endpackage

// File: rtl/scalar_wb_arbiter_rr.sv
// rtl/scalar_wb_arbiter_rr.sv - round-robin arbiter, one-hot grant, pointer kept internally
module rr_arbiter #(
    parameter int NUM_REQ = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_next;
    logic [PW:0]   idx;
    logic          found;

    // Walk from the pointer upward with wrap; the first requester seen wins.
    always_comb begin
        grant    = '0;
        ptr_next = ptr;
        found    = 1'b0;
        idx      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, ptr} + (PW+1)'(k);
            if (idx >= (PW+1)'(NUM_REQ)) begin
                idx = idx - (PW+1)'(NUM_REQ);
            end
            if (!found && req[idx[PW-1:0]]) begin
                found               = 1'b1;
                grant[idx[PW-1:0]]  = 1'b1;
                ptr_next            = (idx[PW-1:0] == PW'(NUM_REQ - 1)) ? '0 : idx[PW-1:0] + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_next;
        end
    end

endmodule

// File: rtl/scalar_wb_arbiter.sv
// rtl/scalar_wb_arbiter.sv - scalar register file write-port arbiter with busy scoreboard
module scalar_wb_arbiter #(
    parameter int NUM_REQ  = scalar_wb_arbiter_pkg::NUM_REQ,
    parameter int DATA_W   = scalar_wb_arbiter_pkg::DATA_W,
    parameter int ADDR_W   = scalar_wb_arbiter_pkg::ADDR_W,
    parameter int NUM_REGS = scalar_wb_arbiter_pkg::NUM_REGS
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_dst,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      wr_en,
    output logic [ADDR_W-1:0]         wr_dst,
    output logic [DATA_W-1:0]         wr_data,
    input  logic                      issue_valid,
    input  logic [ADDR_W-1:0]         issue_dst,
    output logic                      issue_stall,
    input  logic                      rd_en_1,
    input  logic                      rd_en_2,
    input  logic [ADDR_W-1:0]         rd_addr_1,
    input  logic [ADDR_W-1:0]         rd_addr_2,
    output logic                      raw_hazard,
    output logic [NUM_REGS-1:0]       busy_vec,
    output logic                      protocol_err
);

    import scalar_wb_arbiter_pkg::*;

    logic [NUM_REQ-1:0]  grant;
    logic                any_grant;
    logic [ADDR_W-1:0]   sel_dst;
    logic [DATA_W-1:0]   sel_data;
    logic                issue_accept;
    logic [NUM_REGS-1:0] busy_next;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req_valid),
        .grant (grant)
    );

    assign req_ready = grant;
    assign any_grant = |grant;

    always_comb begin
        sel_dst  = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_dst  = req_dst[i*ADDR_W +: ADDR_W];
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // A write retiring this cycle does not free its register until the next cycle.
    assign issue_stall  = issue_valid && busy_vec[issue_dst];
    assign issue_accept = issue_valid && !busy_vec[issue_dst];
    assign raw_hazard   = (rd_en_1 && busy_vec[rd_addr_1]) || (rd_en_2 && busy_vec[rd_addr_2]);

    // Set applied after clear: a fresh issue to the same register keeps it busy.
    always_comb begin
        busy_next = busy_vec;
        if (wr_en) begin
            busy_next[wr_dst] = 1'b0;
        end
        if (issue_accept) begin
            busy_next[issue_dst] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en        <= 1'b0;
            wr_dst       <= '0;
            wr_data      <= '0;
            busy_vec     <= '0;
            protocol_err <= 1'b0;
        end else begin
            wr_en    <= any_grant;
            busy_vec <= busy_next;
            if (any_grant) begin
                wr_dst  <= sel_dst;
                wr_data <= sel_data;
                if (!busy_vec[sel_dst]) begin
                    protocol_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_scalar_wb_arbiter.sv
// tb/tb_scalar_wb_arbiter.sv - randomized model-checked bench for scalar_wb_arbiter
module tb_scalar_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  req_valid = '0;
    logic [8:0]  req_dst = '0;
    logic [47:0] req_data = '0;
    logic [2:0]  req_ready;
    logic        wr_en;
    logic [2:0]  wr_dst;
    logic [15:0] wr_data;
    logic        issue_valid = 1'b0;
    logic [2:0]  issue_dst = '0;
    logic        issue_stall;
    logic        rd_en_1 = 1'b0, rd_en_2 = 1'b0;
    logic [2:0]  rd_addr_1 = '0, rd_addr_2 = '0;
    logic        raw_hazard;
    logic [7:0]  busy_vec;
    logic        protocol_err;

    scalar_wb_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_dst(req_dst), .req_data(req_data), .req_ready(req_ready),
        .wr_en(wr_en), .wr_dst(wr_dst), .wr_data(wr_data),
        .issue_valid(issue_valid), .issue_dst(issue_dst), .issue_stall(issue_stall),
        .rd_en_1(rd_en_1), .rd_en_2(rd_en_2), .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2),
        .raw_hazard(raw_hazard), .busy_vec(busy_vec), .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: plain arrays and integers.
    int        m_ptr;
    bit        m_busy [8];
    bit        m_wen;
    int        m_wdst;
    int        m_wdata;
    bit        m_err;
    int        mg;
    bit        m_stall;
    bit        m_raw;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_wen = 0; m_wdst = 0; m_wdata = 0; m_err = 0; mg = -1;
        for (int r = 0; r < 8; r++) m_busy[r] = 0;
    endtask

    function automatic int dst_of(input int i);
        return int'(req_dst[i*3 +: 3]);
    endfunction

    function automatic int data_of(input int i);
        return int'(req_data[i*16 +: 16]);
    endfunction

    function automatic logic [7:0] busy_bits();
        logic [7:0] b;
        for (int r = 0; r < 8; r++) b[r] = m_busy[r];
        return b;
    endfunction

    // Wait to the low phase, evaluate the rules and compare every output.
    task automatic settle();
        @(negedge clk);
        mg = -1;
        for (int k = 0; k < 3; k++) begin
            if (mg < 0 && req_valid[(m_ptr + k) % 3]) mg = (m_ptr + k) % 3;
        end
        m_stall = issue_valid && m_busy[issue_dst];
        m_raw   = (rd_en_1 && m_busy[rd_addr_1]) || (rd_en_2 && m_busy[rd_addr_2]);
        check("req_ready", 32'(req_ready), (mg < 0) ? 32'd0 : (32'd1 << mg));
        check("issue_stall", 32'(issue_stall), 32'(m_stall));
        check("raw_hazard", 32'(raw_hazard), 32'(m_raw));
        check("busy_vec", 32'(busy_vec), 32'(busy_bits()));
        check("wr_en", 32'(wr_en), 32'(m_wen));
        check("wr_dst", 32'(wr_dst), 32'(m_wdst));
        check("wr_data", 32'(wr_data), 32'(m_wdata));
        check("protocol_err", 32'(protocol_err), 32'(m_err));
    endtask

    task automatic advance();
        bit nb [8];
        nb = m_busy;
        if (m_wen) nb[m_wdst] = 0;
        if (issue_valid && !m_stall) nb[issue_dst] = 1;
        if (mg >= 0) begin
            if (!m_busy[dst_of(mg)]) m_err = 1;
            m_wen   = 1;
            m_wdst  = dst_of(mg);
            m_wdata = data_of(mg);
            m_ptr   = (mg + 1) % 3;
        end else begin
            m_wen = 0;
        end
        m_busy = nb;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic set_req(input int i, input bit v, input logic [2:0] d, input logic [15:0] x);
        req_valid[i] = v;
        req_dst[i*3 +: 3] = d;
        req_data[i*16 +: 16] = x;
    endtask

    initial begin
        int prev_g;
        model_reset();
        do_reset();

        // Idle after reset.
        repeat (3) begin
            settle();
            check("idle_wr_en", 32'(wr_en), 32'd0);
            check("idle_busy", 32'(busy_vec), 32'h00);
            check("idle_err", 32'(protocol_err), 32'd0);
            advance();
        end

        // Single write to r3.
        issue_valid = 1; issue_dst = 3;
        settle(); check("single_issue_stall", 32'(issue_stall), 32'd0); advance();
        issue_valid = 0; set_req(1, 1, 3'd3, 16'hBEEF);
        settle();
        check("single_ready", 32'(req_ready), 32'b010);
        check("single_busy_set", 32'(busy_vec), 32'h08);
        advance();
        set_req(1, 0, 3'd0, 16'h0);
        settle();
        check("single_wr_en", 32'(wr_en), 32'd1);
        check("single_wr_dst", 32'(wr_dst), 32'd3);
        check("single_wr_data", 32'(wr_data), 32'hBEEF);
        advance();
        settle(); check("single_busy_clr", 32'(busy_vec), 32'h00); check("single_err", 32'(protocol_err), 32'd0);
        advance();

        // RAW on r2.
        issue_valid = 1; issue_dst = 2;
        settle(); advance();
        issue_valid = 0; rd_en_1 = 1; rd_addr_1 = 2;
        settle(); check("raw_src1", 32'(raw_hazard), 32'd1);
        rd_en_1 = 0; #1; check("raw_off", 32'(raw_hazard), 32'd0);
        rd_en_2 = 1; rd_addr_2 = 2; #1; check("raw_src2", 32'(raw_hazard), 32'd1);
        advance();
        rd_en_2 = 0;

        // WAW on r5: stall persists through the wr_en cycle, releases the cycle after.
        issue_valid = 1; issue_dst = 5;
        settle(); advance();
        set_req(0, 1, 3'd5, 16'h1234);
        settle(); check("waw_stall0", 32'(issue_stall), 32'd1); advance();
        set_req(0, 0, 3'd0, 16'h0);
        settle(); check("waw_wr_dst", 32'(wr_dst), 32'd5); check("waw_stall1", 32'(issue_stall), 32'd1); advance();
        settle(); check("waw_release", 32'(issue_stall), 32'd0); advance();
        settle(); check("waw_reset_busy", 32'(busy_vec[5]), 32'd1); check("waw_stall2", 32'(issue_stall), 32'd1);
        issue_valid = 0;
        advance();

        // Grant to idle r4 (error), then issue r4 in the wr_en cycle: set wins.
        set_req(2, 1, 3'd4, 16'h4444);
        settle(); check("coll_err_pre", 32'(protocol_err), 32'd0); advance();
        set_req(2, 0, 3'd0, 16'h0); issue_valid = 1; issue_dst = 4;
        settle(); check("coll_wr_dst", 32'(wr_dst), 32'd4); check("coll_err", 32'(protocol_err), 32'd1); advance();
        issue_valid = 0;
        settle(); check("coll_busy4", 32'(busy_vec[4]), 32'd1); advance();
        set_req(0, 1, 3'd6, 16'h6666);
        settle(); advance();
        set_req(0, 0, 3'd0, 16'h0);
        settle(); check("err_wr_data", 32'(wr_data), 32'h6666); check("err_held", 32'(protocol_err), 32'd1);

        // Async reset in the low phase drops the presented write without a clock edge.
        #1 rst_n = 0;
        #1;
        check("async_wr_en", 32'(wr_en), 32'd0);
        check("async_busy", 32'(busy_vec), 32'h00);
        check("async_err", 32'(protocol_err), 32'd0);
        do_reset();

        // Round-robin fairness with all requesters asserted.
        set_req(0, 1, 3'd1, 16'hA000); set_req(1, 1, 3'd1, 16'hA001); set_req(2, 1, 3'd1, 16'hA002);
        for (int k = 0; k < 6; k++) begin
            settle();
            check("rr_grant", 32'(req_ready), 32'd1 << (k % 3));
            if (k > 0) check("rr_wr_en", 32'(wr_en), 32'd1);
            advance();
        end
        req_valid = '0;
        settle(); check("rr_wr_en_last", 32'(wr_en), 32'd1); check("rr_wr_data_last", 32'(wr_data), 32'hA002); advance();
        settle(); check("rr_wr_en_off", 32'(wr_en), 32'd0); advance();

        // Random traffic; requesters hold their request until granted.
        do_reset();
        prev_g = -1;
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) begin
                req_valid = '0; do_reset(); prev_g = -1;
            end
            for (int i = 0; i < 3; i++) begin
                if (i == prev_g || !req_valid[i]) begin
                    if ($urandom_range(1) == 1) begin
                        logic [2:0] d;
                        d = 3'($urandom_range(7));
                        for (int t = 0; t < 8 && $urandom_range(3) != 0; t++) begin
                            if (m_busy[d]) break;
                            d = 3'($urandom_range(7));
                        end
                        set_req(i, 1, d, 16'($urandom));
                    end else begin
                        req_valid[i] = 0;
                    end
                end
            end
            issue_valid = ($urandom_range(2) == 0);
            issue_dst   = 3'($urandom_range(7));
            rd_en_1     = 1'($urandom_range(1));
            rd_en_2     = 1'($urandom_range(1));
            rd_addr_1   = 3'($urandom_range(7));
            rd_addr_2   = 3'($urandom_range(7));
            settle();
            prev_g = mg;
            advance();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/scalar_wb_arbiter.md
Name: scalar_wb_arbiter

Overview:
- Owns the single write port of the 8x16 scalar register file.
- Arbitrates round-robin among NUM_REQ writeback requesters (ALU, load unit, vector-to-scalar move), at most one write per cycle.
- Drives the register file write controls from flops.
- Keeps a busy scoreboard of in-flight writes. Issue logic uses it to stall RAW and WAW hazards.

Parameters:
- NUM_REQ, 3, number of writeback requesters; index 0 = ALU, 1 = load, 2 = vector move.
- DATA_W, 16, register data width.
- ADDR_W, 3, register address width.
- NUM_REGS, 8, register count; must equal 2**ADDR_W.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester writeback request.
- req_dst  in  NUM_REQ*ADDR_W  packed destination; requester i uses bits [i*ADDR_W +: ADDR_W].
- req_data  in  NUM_REQ*DATA_W  packed write data, same packing.
- req_ready  out  NUM_REQ  one-hot grant; combinational from req_valid and the pointer.
- wr_en  out  1  register file write enable, registered.
- wr_dst  out  ADDR_W  register file write address, registered.
- wr_data  out  DATA_W  register file write data, registered.
- issue_valid  in  1  issue stage wants to dispatch an op that writes issue_dst.
- issue_dst  in  ADDR_W  destination of the dispatching op.
- issue_stall  out  1  combinational; the issue is not accepted this cycle.
- rd_en_1, rd_en_2  in  1 each  source operand used.
- rd_addr_1, rd_addr_2  in  ADDR_W each  source operand addresses.
- raw_hazard  out  1  combinational; a used source is busy.
- busy_vec  out  NUM_REGS  scoreboard state.
- protocol_err  out  1  sticky error flag.

Behaviour:
- Reset (async assert, sync deassert handled upstream): rr_ptr=0, busy_vec=0, wr_en=0, wr_dst=0, wr_data=0, protocol_err=0.
- Arbitration: search from rr_ptr upward, wrapping modulo NUM_REQ. The first asserted req_valid wins. Exactly one req_ready bit is high, or none if no request.
  - Handshake completes when valid and ready are both high in the same cycle.
  - A requester holds valid, dst and data stable until ready.
  - req_ready never depends on the requester's own ready.
- Pointer update: on a grant to requester g, rr_ptr <= (g+1) mod NUM_REQ. No grant leaves rr_ptr unchanged.
- Latency: a grant in cycle N gives wr_en=1 with the granted dst/data in cycle N+1, held exactly one cycle. With back-to-back grants, wr_en stays high continuously. With no grant, wr_en=0 and wr_dst/wr_data hold their last values.
- Scoreboard set: issue accepted when issue_valid && !issue_stall. It sets busy[issue_dst] at the edge.
- Scoreboard clear: busy[wr_dst] clears at the edge ending a wr_en=1 cycle. A read in the cycle after wr_en sees the new value.
- Same-register set and clear in one edge: set wins, because a newer write is pending.
- issue_stall = issue_valid && busy[issue_dst] (WAW). The write clearing issue_dst in the current cycle does not count as free; the stall releases one cycle later.
- raw_hazard = (rd_en_1 && busy[rd_addr_1]) || (rd_en_2 && busy[rd_addr_2]). There is no forwarding in this block.
- protocol_err is set (sticky until reset) when a writeback is granted to a dst whose busy bit is 0. The write is still performed.
- Reset mid-operation: all pending state is discarded immediately. Any write registered but not yet presented is dropped (wr_en forced 0).

Decomposition:
- Shared package: DATA_W/ADDR_W/NUM_REGS constants, and requester index constants REQ_ALU=0, REQ_LD=1, REQ_VMOV=2.
- Sub-module rr_arbiter (NUM_REQ parameter): request vector in, one-hot grant out, pointer flops inside. It is reusable for the vector register file write port.
- The scoreboard and write-port flops stay in the top module.

Test Plan:
- Reset then idle: rst_n low for 2 cycles then high -> wr_en=0, busy_vec=8'h00, protocol_err=0 for all idle cycles; async assert mid-cycle clears wr_en with no clock edge.
- Single write: issue_dst=3 accepted; next cycle req_valid[1]=1, dst=3, data=16'hBEEF -> req_ready=3'b010 the same cycle; next cycle wr_en=1, wr_dst=3, wr_data=16'hBEEF; busy[3] goes 1 -> 0 after that edge.
- Round-robin fairness: all three requesters valid continuously, rr_ptr=0 -> grants 0,1,2,0,1,2 on consecutive cycles; wr_en high 6 consecutive cycles.
- WAW stall: busy[5]=1, issue_valid with issue_dst=5 -> issue_stall=1 until the cycle after the wr_en cycle with wr_dst=5, then issue accepted and busy[5]=1 again.
- RAW hazard: busy[2]=1; rd_en_1=1, rd_addr_1=2 -> raw_hazard=1. rd_en_1=0 -> raw_hazard=0. rd_addr_2=2 with rd_en_2=1 -> raw_hazard=1.
- Set/clear collision and error: wr_en with wr_dst=4 in the same cycle as an accepted issue_dst=4 -> busy[4] stays 1. A grant to dst=6 with busy[6]=0 -> write performed, protocol_err=1 and held.
